shift_reg_feeder: RTL and testbench
===================================

Name: shift_reg_feeder

Overview:
- Upstream driver for the team's 32-bit serial/parallel-load shift register.
- Accepts one WIDTH-bit word per valid/ready handshake. Delivers it to the register either as one parallel load or as WIDTH serial shifts.
- Serial delivery is LSB first, so the word's bit 0 lands in register bit 0 after the last shift.
- Asserts done for one cycle when delivery completes.

Parameters:
WIDTH, 32, word width and number of serial shifts per word.
GAP, 1, idle cycles inserted between consecutive shift pulses (0 = back-to-back).

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous active-high reset.
in_valid  input  1  word on in_data is offered.
in_ready  output  1  block can accept a word.
in_data  input  WIDTH  word to deliver.
par_mode  input  1  sampled with the handshake; 1 = parallel load, 0 = serial shift-in.
load  output  1  write strobe to shift register; high exactly one cycle per register update.
S_L  output  1  mode to shift register; 0 = serial, 1 = parallel; valid whenever load=1.
s_in  output  1  serial bit to shift register.
p_in  output  WIDTH  parallel word to shift register.
busy  output  1  high from the cycle after acceptance through the done cycle.
done  output  1  one-cycle pulse when delivery finishes.

Behaviour:
- Reset: asynchronous and active-high.
  - While rst=1, state=IDLE.
  - load, S_L, s_in, busy, done = 0; p_in = 0; internal buffer, bit counter and gap counter = 0.
  - Reset mid-delivery aborts immediately. No further load pulses. The partially shifted register is left as is.
- Timing of outputs:
  - in_ready = (state==IDLE), combinational from state.
  - All other outputs are registered.
- States: IDLE, PLOAD, SHIFT, GAPW, DONE.
- IDLE:
  - in_ready=1, load=0.
  - When in_valid & in_ready: capture in_data into buf and latch par_mode.
  - Clear bit_cnt. Go to PLOAD if par_mode=1, else SHIFT.
  - busy=1 from the next cycle.
- PLOAD (1 cycle):
  - load=1, S_L=1, p_in=buf.
  - Next state DONE.
- SHIFT (1 cycle each):
  - load=1, S_L=0, s_in=buf[0].
  - buf shifts right by 1; bit_cnt increments.
  - If bit_cnt was WIDTH-1, go to DONE.
  - Else if GAP=0, stay in SHIFT.
  - Else load gap_cnt=GAP-1 and go to GAPW.
- GAPW:
  - load=0. s_in, S_L and p_in hold their values.
  - gap_cnt decrements; go to SHIFT when gap_cnt==0.
- DONE (1 cycle):
  - done=1, load=0, busy=1. Next state IDLE.
  - busy and done drop in the following cycle, and in_ready returns to 1 in that same cycle.
- Latency, with acceptance at edge T:
  - First load is visible in cycle T+1.
  - Serial delivery occupies WIDTH + (WIDTH-1)*GAP cycles, followed by 1 done cycle.
  - Parallel delivery is 1 load cycle plus 1 done cycle.
- Handshake rules:
  - in_valid while busy is ignored; no word is accepted; the handshake stalls until in_ready=1.
  - in_data and par_mode matter only in the acceptance cycle.
- Load pulse count: exactly WIDTH pulses per serial word and exactly 1 per parallel word. load is never high in IDLE, GAPW or DONE.
- bit_cnt is ceil(log2(WIDTH+1)) bits wide and never wraps within a word.
- Back-to-back words: the earliest next acceptance is the cycle after DONE. No overlap of done with the next word's first load.

Test Plan:
- Reset mid-serial: after 10 shifts, pulse rst → load=0 and in_ready=1 during reset; no further load pulses; outputs at reset values.
- Serial GAP=1: accept in_data=32'hA5A5_0F0F, par_mode=0 → 32 load pulses with one idle cycle between each.
  - s_in sequence = 1,1,1,1,0,0,0,0,1,1,1,1,0,0,0,0,1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1 (LSB first).
  - Attached 32-bit register reads 32'hA5A5_0F0F.
  - done pulses once, at cycle T+64.
- Serial GAP=0: in_data=32'h8000_0001 → loads on cycles T+1..T+32 consecutively.
  - s_in=1 on the first and last shift only; done at T+33.
- Parallel: in_data=32'hDEAD_BEEF, par_mode=1 → single load with S_L=1 and p_in=32'hDEAD_BEEF at T+1.
  - done at T+2; register reads 32'hDEAD_BEEF.
- Busy stall: hold in_valid=1 with changing in_data during a serial transfer → no second acceptance until in_ready=1.
  - The word present at re-acceptance is the one delivered next; the first word completes unchanged.

Source files
------------

// File: rtl/shift_reg_feeder.sv
// shift_reg_feeder: delivers one WIDTH-bit word per valid/ready handshake to a
// serial/parallel-load shift register, either as a single parallel load or as
// WIDTH LSB-first serial shifts with GAP idle cycles between shift pulses.
module shift_reg_feeder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             par_mode,
  output logic             load,
  output logic             S_L,
  output logic             s_in,
  output logic [WIDTH-1:0] p_in,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned GAP_M1 = (GAP > 0) ? GAP - 1 : 0;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_M1);

  typedef enum logic [2:0] {
    IDLE,
    PLOAD,
    SHIFT,
    GAPW,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] word_buf, buf_nxt;
  logic [CNT_W-1:0] bit_cnt, cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;

  assign in_ready = (state == IDLE);

  // Next-state and datapath update. word_buf[0] is the bit on s_in while in
  // SHIFT; the buffer advances when SHIFT is left, so GAPW already holds the
  // following bit in position 0.
  always_comb begin
    state_nxt = state;
    buf_nxt   = word_buf;
    cnt_nxt   = bit_cnt;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          buf_nxt   = in_data;
          cnt_nxt   = '0;
          state_nxt = par_mode ? PLOAD : SHIFT;
        end
      end
      PLOAD: state_nxt = DONE;
      SHIFT: begin
        buf_nxt = word_buf >> 1;
        cnt_nxt = bit_cnt + 1'b1;
        if (bit_cnt == LAST_BIT) begin
          state_nxt = DONE;
        end else if (GAP == 0) begin
          state_nxt = SHIFT;
        end else begin
          gap_nxt   = GAP_LOAD;
          state_nxt = GAPW;
        end
      end
      GAPW: begin
        if (gap_cnt == '0) begin
          state_nxt = SHIFT;
        end else begin
          gap_nxt = gap_cnt - 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, word buffer and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      word_buf <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      word_buf <= buf_nxt;
      bit_cnt  <= cnt_nxt;
      gap_cnt  <= gap_nxt;
    end
  end

  // Registered outputs, decoded from the state being entered so they line up
  // with that state's cycle; S_L, s_in and p_in hold outside load cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load <= 1'b0;
      S_L  <= 1'b0;
      s_in <= 1'b0;
      p_in <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      load <= (state_nxt == PLOAD) || (state_nxt == SHIFT);
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);
      if (state_nxt == PLOAD) begin
        S_L  <= 1'b1;
        p_in <= buf_nxt;
      end
      if (state_nxt == SHIFT) begin
        S_L  <= 1'b0;
        s_in <= buf_nxt[0];
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_feeder.sv
// Bench for shift_reg_feeder: one instance with GAP=1 (index 0) and one with
// GAP=0 (index 1), each feeding a model of the attached 32-bit shift register.
module tb_shift_reg_feeder;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid [2];
  logic [W-1:0] in_data  [2];
  logic         par_mode [2];
  logic         in_ready [2];
  logic         load     [2];
  logic         S_L      [2];
  logic         s_in     [2];
  logic [W-1:0] p_in     [2];
  logic         busy     [2];
  logic         done     [2];
  logic [W-1:0] sreg     [2];

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  shift_reg_feeder #(.WIDTH(W), .GAP(1)) u_gap1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .par_mode(par_mode[0]), .load(load[0]), .S_L(S_L[0]),
    .s_in(s_in[0]), .p_in(p_in[0]), .busy(busy[0]), .done(done[0])
  );

  shift_reg_feeder #(.WIDTH(W), .GAP(0)) u_gap0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .par_mode(par_mode[1]), .load(load[1]), .S_L(S_L[1]),
    .s_in(s_in[1]), .p_in(p_in[1]), .busy(busy[1]), .done(done[1])
  );

  // Attached shift register: serial data enters at the MSB and moves right,
  // so after W shifts the first bit sent sits in bit 0.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (load[i] === 1'b1)
        sreg[i] <= S_L[i] ? p_in[i] : {s_in[i], sreg[i][W-1:1]};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one word to instance sel and checks every cycle of its delivery
  // against the timeline derived from the word, mode and gap.
  task automatic deliver(input int sel, input logic [W-1:0] word,
                         input logic mode, input bit stall);
    int          gap;
    int          span;
    int          bound;
    int          n_load;
    int          idx;
    bit          exp_ld;
    logic [3:0]  exp_ctl, got_ctl;
    logic [W:0]  exp_dat, got_dat;
    gap   = (sel == 0) ? 1 : 0;
    span  = mode ? 1 : W + (W - 1) * gap;
    bound = 0;
    while (in_ready[sel] !== 1'b1 && bound < 200) begin
      step();
      bound++;
    end
    vectors++;
    if (in_ready[sel] !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_timeout dut%0d: in_ready=%b, want 1", sel, in_ready[sel]);
      return;
    end
    in_valid[sel] = 1'b1;
    in_data[sel]  = word;
    par_mode[sel] = mode;
    step();
    n_load = 0;
    for (int k = 1; k <= span + 1; k++) begin
      if (stall) begin
        in_data[sel]  = $urandom;
        par_mode[sel] = 1'($urandom_range(0, 1));
      end else begin
        in_valid[sel] = 1'b0;
      end
      exp_ld  = (k <= span) && (((k - 1) % (gap + 1)) == 0);
      exp_ctl = {exp_ld, (k == span + 1), 1'b1, 1'b0};
      got_ctl = {load[sel], done[sel], busy[sel], in_ready[sel]};
      vectors++;
      if (got_ctl !== exp_ctl) begin
        miscompares++;
        $display("FAIL ctl dut%0d k=%0d: {load,done,busy,in_ready}=%b, want %b",
                 sel, k, got_ctl, exp_ctl);
      end
      if (load[sel] === 1'b1) n_load++;
      if (exp_ld) begin
        idx     = (k - 1) / (gap + 1);
        exp_dat = mode ? {1'b1, word} : {1'b0, {(W-1){1'b0}}, word[idx]};
        got_dat = mode ? {S_L[sel], p_in[sel]} : {S_L[sel], {(W-1){1'b0}}, s_in[sel]};
        vectors++;
        if (got_dat !== exp_dat) begin
          miscompares++;
          $display("FAIL data dut%0d k=%0d: {S_L,data}=%h, want %h", sel, k, got_dat, exp_dat);
        end
      end
      if (k == span + 1) begin
        vectors++;
        if (sreg[sel] !== word) begin
          miscompares++;
          $display("FAIL reg dut%0d: register=%h, want %h", sel, sreg[sel], word);
        end
      end
      step();
    end
    got_ctl = {load[sel], done[sel], busy[sel], in_ready[sel]};
    vectors++;
    if (got_ctl !== 4'b0001) begin
      miscompares++;
      $display("FAIL post_done dut%0d: {load,done,busy,in_ready}=%b, want 0001", sel, got_ctl);
    end
    vectors++;
    if (n_load != (mode ? 1 : W)) begin
      miscompares++;
      $display("FAIL load_count dut%0d: %0d pulses, want %0d", sel, n_load, mode ? 1 : W);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [5:0] got;
    for (int i = 0; i < 2; i++) begin
      got = {load[i], S_L[i], s_in[i], busy[i], done[i], in_ready[i]};
      vectors++;
      if (got !== 6'b000001 || p_in[i] !== '0) begin
        miscompares++;
        $display("FAIL %s dut%0d: {load,S_L,s_in,busy,done,in_ready}=%b p_in=%h, want 000001 p_in=0",
                 tag, i, got, p_in[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    check_reset_outputs("reset_state");
    rst = 1'b0;
    step();
    check_reset_outputs("after_release");
  endtask

  task automatic test_directed();
    deliver(0, 32'hA5A5_0F0F, 1'b0, 1'b0);
    deliver(1, 32'h8000_0001, 1'b0, 1'b0);
    deliver(0, 32'hDEAD_BEEF, 1'b1, 1'b0);
    deliver(1, 32'h1234_5678, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) deliver(0, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 8; i++) deliver(1, $urandom, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic test_busy_stall();
    for (int s = 0; s < 2; s++) begin
      deliver(s, $urandom, 1'b0, 1'b1);
      deliver(s, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_reset_mid_serial();
    int n_load;
    in_valid[0] = 1'b1;
    in_data[0]  = $urandom;
    par_mode[0] = 1'b0;
    step();
    in_valid[0] = 1'b0;
    n_load = 0;
    for (int k = 1; k <= 19; k++) begin
      if (load[0] === 1'b1) n_load++;
      if (k < 19) step();
    end
    vectors++;
    if (n_load != 10) begin
      miscompares++;
      $display("FAIL pre_reset_loads: %0d pulses, want 10", n_load);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    for (int k = 0; k < 3; k++) begin
      step();
      check_reset_outputs("reset_hold");
    end
    rst = 1'b0;
    n_load = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (load[0] === 1'b1 || load[1] === 1'b1) n_load++;
    end
    vectors++;
    if (n_load != 0) begin
      miscompares++;
      $display("FAIL loads_after_reset: %0d pulses, want 0", n_load);
    end
    check_reset_outputs("idle_after_reset");
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
      par_mode[i] = 1'b0;
    end
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_busy_stall();
    test_reset_mid_serial();
    deliver(0, $urandom, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
